// File: rtl/ppm_tx_sched.sv
// ppm_tx_sched -- byte-to-PPM transmit scheduler.
//
// Each accepted byte becomes a frame made of two 16-slot PPM symbols and a
// guard gap. The high nibble is sent first (SYM_HI), then the low nibble
// (SYM_LO). Every slot is SLOT_CYC clocks long. The pulse line is high for
// exactly the slot whose index equals the nibble value. After both symbols,
// GUARD_SLOTS idle slots follow. A new byte may be accepted on the final
// guard cycle, so frames can run back-to-back with no idle gap.
//
// Parameters
//   SLOT_CYC     clock cycles per slot (1..255)
//   GUARD_SLOTS  idle slots after each frame (1..15)
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   ena          global enable; low freezes every counter and register
//   in_valid     byte-available qualifier
//   in_data      byte to transmit, latched on accept
//   in_ready     scheduler can take a byte this cycle
//   ppm_out      registered PPM pulse line
//   frame_start  one-cycle strobe on the first cycle of each frame
//   busy         high whenever the FSM is not IDLE
//   tx_count     completed frames, modulo 256
//   dbg_state    current FSM state, for observation only
//
// Handshake: a byte transfers on a rising edge where in_valid, in_ready and
// ena are all high. in_ready is combinational from registered state, so it
// does not depend on in_valid. in_valid is ignored in every other cycle.
module ppm_tx_sched #(
  parameter int SLOT_CYC    = 4,
  parameter int GUARD_SLOTS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       ppm_out,
  output logic       frame_start,
  output logic       busy,
  output logic [7:0] tx_count,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYM_HI = 2'd1,
    SYM_LO = 2'd2,
    GUARD  = 2'd3
  } state_e;

  // Cycle-in-slot counter only has to reach SLOT_CYC-1.
  localparam int              CW         = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam logic [CW-1:0]   CYC_LAST   = CW'(SLOT_CYC - 1);
  // Slot counter is 4 bits: it reaches 15 in the symbols, at most 14 in GUARD.
  localparam logic [3:0]      GUARD_LAST = 4'(GUARD_SLOTS - 1);

  state_e        state_q, state_d;
  logic [3:0]    slot_q, slot_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          fs_q, fs_d;
  logic          ppm_q, ppm_d;

  logic last_cyc;
  logic guard_last;
  logic accept;

  assign last_cyc   = (cyc_q == CYC_LAST);
  assign guard_last = (state_q == GUARD) && (slot_q == GUARD_LAST) && last_cyc;

  assign in_ready    = rst_n & ena & ((state_q == IDLE) | guard_last);
  assign accept      = in_valid & in_ready;
  // The strobe register holds while disabled; the output is forced low.
  assign frame_start = fs_q & ena;
  assign busy        = (state_q != IDLE);
  assign ppm_out     = ppm_q;
  assign tx_count    = cnt_q;
  assign dbg_state   = state_q;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cyc_d   = cyc_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    fs_d    = fs_q;
    ppm_d   = ppm_q;

    if (ena) begin
      fs_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = SYM_HI;
            slot_d  = '0;
            cyc_d   = '0;
            data_d  = in_data;
            fs_d    = 1'b1;
          end
        end
        SYM_HI, SYM_LO: begin
          if (last_cyc) begin
            cyc_d = '0;
            if (slot_q == 4'd15) begin
              slot_d  = '0;
              state_d = (state_q == SYM_HI) ? SYM_LO : GUARD;
            end else begin
              slot_d = slot_q + 4'd1;
            end
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        GUARD: begin
          if (last_cyc) begin
            cyc_d = '0;
            if (slot_q == GUARD_LAST) begin
              cnt_d  = cnt_q + 8'd1;
              slot_d = '0;
              if (accept) begin
                // Back-to-back frame: skip IDLE entirely.
                state_d = SYM_HI;
                data_d  = in_data;
                fs_d    = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end else begin
              slot_d = slot_q + 4'd1;
            end
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      // Pulse decided from the next position so the output is a clean flop.
      ppm_d = ((state_d == SYM_HI) && (slot_d == data_d[7:4])) ||
              ((state_d == SYM_LO) && (slot_d == data_d[3:0]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      cyc_q   <= '0;
      data_q  <= 8'h00;
      cnt_q   <= 8'h00;
      fs_q    <= 1'b0;
      ppm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cyc_q   <= cyc_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      fs_q    <= fs_d;
      ppm_q   <= ppm_d;
    end
  end

endmodule

// File: tb/tb_ppm_tx_sched.sv
// Bench for ppm_tx_sched: reset checks, a table of directed cycle probes for
// the default configuration, a long frame run for the tx_count wrap, and a
// randomized run on two configurations compared to a frame-position model.
module tb_ppm_tx_sched;

  localparam int S_A = 4, G_A = 2;
  localparam int S_B = 1, G_B = 1;
  localparam int NCAP = 280;

  // ---------------- clock / reset / DUTs ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       a_rdy, a_ppm, a_fs, a_busy;
  logic [7:0] a_tx;
  logic [1:0] a_dbg;
  logic       b_rdy, b_ppm, b_fs, b_busy;
  logic [7:0] b_tx;
  logic [1:0] b_dbg;

  always #5 clk = ~clk;

  ppm_tx_sched #(.SLOT_CYC(S_A), .GUARD_SLOTS(G_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_rdy), .ppm_out(a_ppm), .frame_start(a_fs), .busy(a_busy),
    .tx_count(a_tx), .dbg_state(a_dbg)
  );

  ppm_tx_sched #(.SLOT_CYC(S_B), .GUARD_SLOTS(G_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_rdy), .ppm_out(b_ppm), .frame_start(b_fs), .busy(b_busy),
    .tx_count(b_tx), .dbg_state(b_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is (32+G)*S enabled cycles long; pos is the offset into it.
  typedef struct {
    bit         active;
    int         pos;
    logic [7:0] b;
    logic [7:0] cnt;
  } mdl_t;

  mdl_t ma, mb;

  function automatic logic m_ppm(mdl_t m, int s);
    int sym, slot;
    logic [3:0] nib;
    if (!m.active || m.pos >= 32 * s) return 1'b0;
    sym  = m.pos / (16 * s);
    slot = (m.pos % (16 * s)) / s;
    nib  = (sym == 0) ? m.b[7:4] : m.b[3:0];
    return (slot == int'(nib));
  endfunction

  function automatic logic m_rdy(mdl_t m, int s, int g, logic en);
    return en && (!m.active || m.pos == (32 + g) * s - 1);
  endfunction

  function automatic mdl_t m_step(mdl_t m, int s, int g, logic en, logic v, logic [7:0] d);
    mdl_t n;
    logic acc;
    n   = m;
    acc = v && m_rdy(m, s, g, en);
    if (!en) return n;
    if (m.active && m.pos != (32 + g) * s - 1) begin
      n.pos = m.pos + 1;
    end else begin
      if (m.active) n.cnt = m.cnt + 8'd1;
      if (acc) begin
        n.active = 1'b1;
        n.pos    = 0;
        n.b      = d;
      end else begin
        n.active = 1'b0;
      end
    end
    return n;
  endfunction

  task automatic check_model(input string tag, input mdl_t m, input int s, input int g,
                             input logic ppm, input logic bsy, input logic fs,
                             input logic rdy, input logic [7:0] tx);
    chk1({tag, "_ppm"}, ppm, m_ppm(m, s));
    chk1({tag, "_busy"}, bsy, m.active);
    chk1({tag, "_fs"}, fs, ena && m.active && (m.pos == 0));
    chk1({tag, "_rdy"}, rdy, m_rdy(m, s, g, ena));
    chk8({tag, "_tx"}, tx, m.cnt);
  endtask

  // ---------------- driver tasks ----------------
  // Leaves the bench #1 after a rising edge with the DUTs in IDLE.
  task automatic do_reset();
    rst_n    = 1'b0;
    ena      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Inputs for cycle c of a directed scenario; cycle 0 is the accept cycle.
  task automatic drive_cycle(input int mode, input int c, input logic [7:0] x);
    ena      = 1'b1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = x;
    case (mode)
      0: in_valid = (c == 0);
      1: begin
        in_valid = 1'b1;
        in_data  = (c == 0) ? 8'h00 : 8'hFF;
      end
      2: begin
        in_valid = (c == 0);
        ena      = !(c >= 30 && c <= 39);
      end
      3: begin
        in_valid = (c == 0);
        rst_n    = !(c >= 50 && c <= 52);
      end
      4: begin
        in_valid = (c == 0) || (c == 80) || (c == 81);
        in_data  = (c >= 80) ? 8'h77 : x;
      end
      default: ;
    endcase
  endtask

  logic       cap_ppm [NCAP];
  logic       cap_busy[NCAP];
  logic       cap_fs  [NCAP];
  logic       cap_rdy [NCAP];
  logic [7:0] cap_tx  [NCAP];

  task automatic run_capture(input int mode, input logic [7:0] x);
    do_reset();
    for (int c = 0; c < NCAP; c++) begin
      drive_cycle(mode, c, x);
      @(negedge clk);
      cap_ppm[c]  = a_ppm;
      cap_busy[c] = a_busy;
      cap_fs[c]   = a_fs;
      cap_rdy[c]  = a_rdy;
      cap_tx[c]   = a_tx;
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int         mode;
    logic [7:0] x;
    int         cyc;
    logic [3:0] pbfr;  // expected {ppm, busy, frame_start, in_ready}
    logic [7:0] tx;
  } vec_t;

  vec_t vt[$];

  task automatic add_v(input int mode, input logic [7:0] x, input int cyc,
                       input logic [3:0] pbfr, input logic [7:0] tx);
    vec_t v;
    v.mode = mode; v.x = x; v.cyc = cyc; v.pbfr = pbfr; v.tx = tx;
    vt.push_back(v);
  endtask

  // ---------------- main test ----------------
  initial begin
    int   last_mode;
    logic [7:0] last_x;
    int   wrap_end;

    // Byte 0x3A, single frame
    add_v(0, 8'h3A,   0, 4'b0001, 8'd0);
    add_v(0, 8'h3A,   1, 4'b0110, 8'd0);
    add_v(0, 8'h3A,  12, 4'b0100, 8'd0);
    add_v(0, 8'h3A,  13, 4'b1100, 8'd0);
    add_v(0, 8'h3A,  16, 4'b1100, 8'd0);
    add_v(0, 8'h3A,  17, 4'b0100, 8'd0);
    add_v(0, 8'h3A, 104, 4'b0100, 8'd0);
    add_v(0, 8'h3A, 105, 4'b1100, 8'd0);
    add_v(0, 8'h3A, 108, 4'b1100, 8'd0);
    add_v(0, 8'h3A, 109, 4'b0100, 8'd0);
    add_v(0, 8'h3A, 128, 4'b0100, 8'd0);
    add_v(0, 8'h3A, 129, 4'b0100, 8'd0);
    add_v(0, 8'h3A, 136, 4'b0101, 8'd0);
    add_v(0, 8'h3A, 137, 4'b0001, 8'd1);
    // 0x00 then 0xFF, valid held
    add_v(1, 8'h00,   1, 4'b1110, 8'd0);
    add_v(1, 8'h00,   4, 4'b1100, 8'd0);
    add_v(1, 8'h00,   5, 4'b0100, 8'd0);
    add_v(1, 8'h00,  65, 4'b1100, 8'd0);
    add_v(1, 8'h00,  68, 4'b1100, 8'd0);
    add_v(1, 8'h00,  69, 4'b0100, 8'd0);
    add_v(1, 8'h00, 136, 4'b0101, 8'd0);
    add_v(1, 8'h00, 137, 4'b0110, 8'd1);
    add_v(1, 8'h00, 196, 4'b0100, 8'd1);
    add_v(1, 8'h00, 197, 4'b1100, 8'd1);
    add_v(1, 8'h00, 200, 4'b1100, 8'd1);
    add_v(1, 8'h00, 201, 4'b0100, 8'd1);
    add_v(1, 8'h00, 261, 4'b1100, 8'd1);
    add_v(1, 8'h00, 264, 4'b1100, 8'd1);
    add_v(1, 8'h00, 265, 4'b0100, 8'd1);
    add_v(1, 8'h00, 272, 4'b0101, 8'd1);
    add_v(1, 8'h00, 273, 4'b0110, 8'd2);
    // 0x55 with ena low for cycles 30..39
    add_v(2, 8'h55,  21, 4'b1100, 8'd0);
    add_v(2, 8'h55,  24, 4'b1100, 8'd0);
    add_v(2, 8'h55,  25, 4'b0100, 8'd0);
    add_v(2, 8'h55,  30, 4'b0100, 8'd0);
    add_v(2, 8'h55,  39, 4'b0100, 8'd0);
    add_v(2, 8'h55,  85, 4'b0100, 8'd0);
    add_v(2, 8'h55,  95, 4'b1100, 8'd0);
    add_v(2, 8'h55,  98, 4'b1100, 8'd0);
    add_v(2, 8'h55,  99, 4'b0100, 8'd0);
    add_v(2, 8'h55, 146, 4'b0101, 8'd0);
    add_v(2, 8'h55, 147, 4'b0001, 8'd1);
    // 0xC3 with reset at cycle 50 for 3 cycles (pulse was at 49..52)
    add_v(3, 8'hC3,  48, 4'b0100, 8'd0);
    add_v(3, 8'hC3,  49, 4'b1100, 8'd0);
    add_v(3, 8'hC3,  50, 4'b0000, 8'd0);
    add_v(3, 8'hC3,  52, 4'b0000, 8'd0);
    add_v(3, 8'hC3,  53, 4'b0001, 8'd0);
    add_v(3, 8'hC3, 100, 4'b0001, 8'd0);
    add_v(3, 8'hC3, 200, 4'b0001, 8'd0);
    // 0x3A with in_valid/0x77 pulsed during SYM_LO
    add_v(4, 8'h3A,  80, 4'b0100, 8'd0);
    add_v(4, 8'h3A,  93, 4'b0100, 8'd0);
    add_v(4, 8'h3A, 104, 4'b0100, 8'd0);
    add_v(4, 8'h3A, 105, 4'b1100, 8'd0);
    add_v(4, 8'h3A, 108, 4'b1100, 8'd0);
    add_v(4, 8'h3A, 109, 4'b0100, 8'd0);
    add_v(4, 8'h3A, 137, 4'b0001, 8'd1);
    add_v(4, 8'h3A, 138, 4'b0001, 8'd1);

    // ---- reset state ----
    rst_n = 1'b0;
    ena   = 1'b1;
    #3;
    chk1("rst_a_rdy", a_rdy, 1'b0);
    chk1("rst_a_ppm", a_ppm, 1'b0);
    chk1("rst_a_busy", a_busy, 1'b0);
    chk1("rst_a_fs", a_fs, 1'b0);
    chk8("rst_a_tx", a_tx, 8'h00);
    chk8("rst_a_state", {6'b0, a_dbg}, 8'h00);
    chk1("rst_b_rdy", b_rdy, 1'b0);
    chk1("rst_b_busy", b_busy, 1'b0);
    chk8("rst_b_state", {6'b0, b_dbg}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk1("post_rst_a_rdy", a_rdy, 1'b1);
    chk1("post_rst_b_rdy", b_rdy, 1'b1);
    ena = 1'b0;
    #1;
    chk1("post_rst_a_rdy_noena", a_rdy, 1'b0);

    // ---- directed table ----
    last_mode = -1;
    last_x    = 8'h00;
    foreach (vt[i]) begin
      if (vt[i].mode != last_mode || vt[i].x != last_x) begin
        run_capture(vt[i].mode, vt[i].x);
        last_mode = vt[i].mode;
        last_x    = vt[i].x;
      end
      chk1($sformatf("m%0d_c%0d_ppm", vt[i].mode, vt[i].cyc), cap_ppm[vt[i].cyc], vt[i].pbfr[3]);
      chk1($sformatf("m%0d_c%0d_busy", vt[i].mode, vt[i].cyc), cap_busy[vt[i].cyc], vt[i].pbfr[2]);
      chk1($sformatf("m%0d_c%0d_fs", vt[i].mode, vt[i].cyc), cap_fs[vt[i].cyc], vt[i].pbfr[1]);
      chk1($sformatf("m%0d_c%0d_rdy", vt[i].mode, vt[i].cyc), cap_rdy[vt[i].cyc], vt[i].pbfr[0]);
      chk8($sformatf("m%0d_c%0d_tx", vt[i].mode, vt[i].cyc), cap_tx[vt[i].cyc], vt[i].tx);
    end

    // ---- tx_count wrap over 256 back-to-back frames ----
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'($urandom_range(0, 255));
    wrap_end = 136 * 256;
    for (int c = 0; c <= wrap_end + 1; c++) begin
      @(negedge clk);
      if (c == 136 * 128 + 1) chk8("wrap_tx_mid", a_tx, 8'd128);
      if (c == 136 * 255 + 1) chk8("wrap_tx_255", a_tx, 8'hFF);
      if (c == wrap_end) begin
        chk8("wrap_tx_last", a_tx, 8'hFF);
        chk1("wrap_rdy_last", a_rdy, 1'b1);
        chk1("wrap_busy_last", a_busy, 1'b1);
      end
      if (c == wrap_end + 1) begin
        chk8("wrap_tx_zero", a_tx, 8'h00);
        chk1("wrap_fs", a_fs, 1'b1);
      end
      @(posedge clk);
      #1;
    end

    // ---- randomized run, both configurations ----
    do_reset();
    ma = '{active: 1'b0, pos: 0, b: 8'h00, cnt: 8'h00};
    mb = '{active: 1'b0, pos: 0, b: 8'h00, cnt: 8'h00};
    for (int c = 0; c < 3000; c++) begin
      ena      = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 1) == 1);
      in_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      check_model("rnd_a", ma, S_A, G_A, a_ppm, a_busy, a_fs, a_rdy, a_tx);
      check_model("rnd_b", mb, S_B, G_B, b_ppm, b_busy, b_fs, b_rdy, b_tx);
      ma = m_step(ma, S_A, G_A, ena, in_valid, in_data);
      mb = m_step(mb, S_B, G_B, ena, in_valid, in_data);
      @(posedge clk);
      #1;
    end

    // ---- report ----
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
